// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM timekeeping block: FSM states, field limits,
// blank masks and the BCD step helper used by every two-digit counter.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;

  localparam logic [3:0] BLANK_NONE = 4'b0000;
  localparam logic [3:0] BLANK_HR   = 4'b1100;
  localparam logic [3:0] BLANK_MIN  = 4'b0011;

  // Next value of a packed {tens,ones} BCD pair, wrapping to 00 after max.
  function automatic logic [7:0] bcd_step(input logic [7:0] cur, input logic [7:0] max);
    logic [7:0] nxt;
    if (cur == max) begin
      nxt = 8'h00;
    end else if (cur[3:0] >= 4'd9) begin
      nxt = {cur[7:4] + 4'd1, 4'd0};
    end else begin
      nxt = {cur[7:4], cur[3:0] + 4'd1};
    end
    return nxt;
  endfunction

  function automatic logic [3:0] blank_for(input mode_e m, input logic phase);
    logic [3:0] b;
    b = BLANK_NONE;
    if (phase) begin
      case (m)
        SET_HR:  b = BLANK_HR;
        SET_MIN: b = BLANK_MIN;
        default: b = BLANK_NONE;
      endcase
    end else begin
      b = BLANK_NONE;
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping from MAX to 00; carry pulses with the wrapping increment.
module bcd_wrap_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = {4'(MAX / 10), 4'(MAX % 10)};

  logic [7:0] val_q, val_d;

  // Clear has priority; carry is independent of clear so a rollover still propagates.
  always_comb begin
    val_d = val_q;
    carry = inc & (val_q == MAX_BCD);
    if (clr) begin
      val_d = 8'h00;
    end else if (inc) begin
      val_d = bcd_step(val_q, MAX_BCD);
    end else begin
      val_d = val_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

  assign tens = val_q[7:4];
  assign ones = val_q[3:0];

endmodule

// File: rtl/time_set_controller.sv
// HH:MM timekeeping with a two-button set mode; drives BCD digits, a blink
// blank mask and the current mode to the display multiplexer.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int BLINK_TICKS   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] blank,
  output logic [1:0] mode
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  mode_e         state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    blank_q, blank_d;
  logic          mode_lvl_q, mode_prev_q, up_lvl_q, up_prev_q;

  logic mode_edge_s, up_edge_s, tick_s, sec_clr_s;
  logic min_inc_s, hr_inc_s, sec_carry_s, min_carry_s, hr_carry_s;
  logic [3:0] sec_tens_s, sec_ones_s;
  logic unused_s;

  // Next state; a simultaneous up edge is dropped in favour of the mode edge.
  always_comb begin
    mode_edge_s = mode_lvl_q & ~mode_prev_q;
    up_edge_s   = up_lvl_q & ~up_prev_q & ~mode_edge_s;
    state_d     = state_q;
    case (state_q)
      RUN:     state_d = mode_edge_s ? SET_HR  : RUN;
      SET_HR:  state_d = mode_edge_s ? SET_MIN : SET_HR;
      SET_MIN: state_d = mode_edge_s ? RUN     : SET_MIN;
      default: state_d = RUN;
    endcase
  end

  // Prescaler and counter steering; outside RUN the seconds chain is parked at zero.
  always_comb begin
    tick_s    = (state_q == RUN) && (presc_q == PW'(TICKS_PER_SEC - 1));
    sec_clr_s = (state_d != RUN);
    presc_d   = presc_q + PW'(1);
    if ((state_q != RUN) || (state_d != RUN) || tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (state_q == RUN) begin
      min_inc_s = sec_carry_s;
      hr_inc_s  = min_carry_s;
    end else begin
      min_inc_s = (state_q == SET_MIN) && up_edge_s;
      hr_inc_s  = (state_q == SET_HR) && up_edge_s;
    end
  end

  // Blink phase restarts visible on entering a SET state or on each accepted increment.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_d == RUN) begin
      blink_cnt_d = {BW{1'b0}};
      phase_d     = 1'b0;
    end else if ((state_d != state_q) || up_edge_s) begin
      blink_cnt_d = {BW{1'b0}};
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
      blink_cnt_d = {BW{1'b0}};
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
    blank_d = blank_for(state_d, phase_d);
  end

  // Control, button history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      presc_q     <= {PW{1'b0}};
      blink_cnt_q <= {BW{1'b0}};
      phase_q     <= 1'b0;
      blank_q     <= BLANK_NONE;
      mode_lvl_q  <= 1'b0;
      mode_prev_q <= 1'b0;
      up_lvl_q    <= 1'b0;
      up_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
      mode_lvl_q  <= btn_mode;
      mode_prev_q <= mode_lvl_q;
      up_lvl_q    <= btn_up;
      up_prev_q   <= up_lvl_q;
    end
  end

  bcd_wrap_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(tick_s), .clr(sec_clr_s),
    .tens(sec_tens_s), .ones(sec_ones_s), .carry(sec_carry_s)
  );

  bcd_wrap_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc_s), .clr(1'b0),
    .tens(min_tens), .ones(min_ones), .carry(min_carry_s)
  );

  bcd_wrap_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc_s), .clr(1'b0),
    .tens(hr_tens), .ones(hr_ones), .carry(hr_carry_s)
  );

  assign unused_s = &{sec_tens_s, sec_ones_s, hr_carry_s};
  assign mode     = state_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Randomised and directed bench for time_set_controller against a seconds-of-day reference model.
module tb_time_set_controller;

  localparam int T = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, blank;
  logic [1:0] mode;

  time_set_controller #(.TICKS_PER_SEC(T), .BLINK_TICKS(B)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .blank(blank), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_hh, m_mm, m_ss, m_presc, m_st, m_cnt, m_ph;
  bit m1, m2, u1, u2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; m_st = 0; m_cnt = 0; m_ph = 0;
    m1 = 1'b0; m2 = 1'b0; u1 = 1'b0; u2 = 1'b0;
  endfunction

  function automatic void model_clock();
    bit mev, uev;
    int nst, sod;
    mev = m1 && !m2;
    uev = u1 && !u2 && !mev;
    nst = mev ? (m_st + 1) % 3 : m_st;
    if (m_st == 0) begin
      if (m_presc == T - 1) begin
        m_presc = 0;
        sod  = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
        m_hh = sod / 3600;
        m_mm = (sod / 60) % 60;
        m_ss = sod % 60;
      end else begin
        m_presc++;
      end
    end else if (m_st == 1 && uev) begin
      m_hh = (m_hh + 1) % 24;
    end else if (m_st == 2 && uev) begin
      m_mm = (m_mm + 1) % 60;
    end
    if (nst != 0) begin
      m_presc = 0;
      m_ss = 0;
    end
    if (nst == 0 || nst != m_st || uev) begin
      m_cnt = 0;
      m_ph = 0;
    end else if (m_cnt == B - 1) begin
      m_cnt = 0;
      m_ph = 1 - m_ph;
    end else begin
      m_cnt++;
    end
    m_st = nst;
    m2 = m1; m1 = btn_mode;
    u2 = u1; u1 = btn_up;
  endfunction

  function automatic logic [15:0] exp_digits();
    return {4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10)};
  endfunction

  function automatic logic [3:0] exp_blank();
    if (m_ph == 0) return 4'h0;
    return (m_st == 1) ? 4'hC : (m_st == 2) ? 4'h3 : 4'h0;
  endfunction

  function automatic logic [15:0] digits();
    return {hr_tens, hr_ones, min_tens, min_ones};
  endfunction

  task automatic step();
    if (!rst) model_clock();
    @(posedge clk);
    #1;
    if (!rst) begin
      check("digits", 32'(digits()), 32'(exp_digits()));
      check("mode", 32'(mode), 32'(m_st));
      check("blank", 32'(blank), 32'(exp_blank()));
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic press_up();
    btn_up = 1'b1; step();
    btn_up = 1'b0; step();
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && m_st != target; i++) press_mode();
  endtask

  task automatic set_time(input int h, input int m);
    goto_mode(1);
    for (int i = 0; i < 24 && m_hh != h; i++) press_up();
    goto_mode(2);
    for (int i = 0; i < 60 && m_mm != m; i++) press_up();
    goto_mode(0);
  endtask

  initial begin
    logic [3:0] blink_seq [6];
    int start_hh, start_mm, n;
    blink_seq = '{4'h0, 4'hC, 4'hC, 4'h0, 4'h0, 4'hC};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_digits", 32'(digits()), 32'h0);
    check("por_blank", 32'(blank), 32'h0);
    #2 rst = 1'b0;

    // Async reset mid-count, with btn_mode held through it
    set_time(12, 34);
    repeat (3) step();
    check("preset_1234", 32'(digits()), 32'h1234);
    btn_mode = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_digits", 32'(digits()), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    step(); step();
    model_reset();
    #2 rst = 1'b0;
    step(); step();
    check("held_mode_fires", 32'(mode), 32'h1);
    btn_mode = 1'b0;

    // Blink sequence in SET_HR, then an increment forces visible
    for (int i = 0; i < 6; i++) begin
      step();
      check("blink_seq", 32'(blank), 32'(blink_seq[i]));
    end
    press_up();
    check("up_forces_visible", 32'(blank), 32'h0);
    check("hr_inc", 32'(digits()), 32'h0100);

    // 24 hour increments return to start
    for (int i = 0; i < 24; i++) press_up();
    check("hr_wrap24", 32'(digits()), 32'h0100);
    check("hr_wrap_mode", 32'(mode), 32'h1);
    check("hr_blank_low", 32'(blank & 4'h3), 32'h0);

    // Minute wrap in SET_MIN without hour carry, then full first minute in RUN
    set_time(10, 59);
    goto_mode(2);
    press_up();
    check("min_wrap_no_carry", 32'(digits()), 32'h1000);
    press_mode();
    check("back_to_run", 32'(mode), 32'h0);
    n = 0;
    while (min_ones == 4'd0 && n < 300) begin
      step();
      n++;
    end
    check("first_minute_len", 32'(n), 32'd240);

    // Full-day rollover 23:59:59 -> 00:00:00
    set_time(23, 59);
    repeat (239) step();
    check("pre_rollover", 32'(digits()), 32'h2359);
    step();
    check("rollover", 32'(digits()), 32'h0000);

    // Simultaneous edges: mode wins; a held button increments once
    goto_mode(1);
    start_hh = m_hh;
    btn_mode = 1'b1; btn_up = 1'b1;
    step();
    btn_mode = 1'b0;
    repeat (10) step();
    check("simul_mode", 32'(mode), 32'h2);
    check("simul_hr_same", 32'({hr_tens, hr_ones}), 32'({4'(start_hh / 10), 4'(start_hh % 10)}));
    btn_up = 1'b0;
    step();
    start_mm = m_mm;
    btn_up = 1'b1;
    repeat (10) step();
    btn_up = 1'b0;
    step();
    check("hold_one_inc", 32'({min_tens, min_ones}),
          32'({4'(((start_mm + 1) % 60) / 10), 4'(((start_mm + 1) % 60) % 10)}));

    // Random button activity
    goto_mode(0);
    for (int i = 0; i < 1500; i++) begin
      btn_mode = ($urandom_range(0, 19) == 0);
      btn_up   = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
